// File: rtl/sc_store_unit_pkg.sv
// sc_store_unit_pkg: shared constants and FSM state encoding for the SC store unit
package sc_store_unit_pkg;
  localparam logic FLUSH        = 1'b1;
  localparam logic EXCEPTION    = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic SC_SUCCESS   = 1'b1;
  localparam logic SC_FAIL      = 1'b0;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } sc_state_e;
endpackage

// File: rtl/sc_store_unit_if.sv
// sc_store_unit_if: SRAM-like data-memory store channel between the SC unit and memory
interface sc_store_unit_if #(parameter int ADDR_W = 32);
  logic              mem_req_o;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_wsel_o;
  logic              mem_addr_ok_i;
  logic              mem_data_ok_i;
  modport master (
    output mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, mem_wsel_o,
    input  mem_addr_ok_i, mem_data_ok_i
  );
  modport slave (
    input  mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, mem_wsel_o,
    output mem_addr_ok_i, mem_data_ok_i
  );
endinterface

// File: rtl/sc_store_unit_llsc_link_reg.sv
// llsc_link_reg: LL link bit and linked address with exception-clear > SC-clear > LL-set priority
module llsc_link_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_exc,
  input  logic              clr_sc,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              llbit,
  output logic [ADDR_W-1:0] link_addr
);
  // link state: an exception flush beats SC resolution, which beats a new LL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llbit     <= 1'b0;
      link_addr <= '0;
    end else if (clr_exc || clr_sc) begin
      llbit <= 1'b0;
    end else if (set) begin
      llbit     <= 1'b1;
      link_addr <= set_addr;
    end
  end
endmodule

// File: rtl/sc_store_unit.sv
// sc_store_unit: resolves SC against the LL link, issuing the conditional store or failing locally
module sc_store_unit
  import sc_store_unit_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit CHECK_ADDR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  flush_cause,
  input  logic                  ll_valid_i,
  input  logic [ADDR_W-1:0]     ll_addr_i,
  input  logic                  sc_valid_i,
  input  logic [ADDR_W-1:0]     sc_addr_i,
  input  logic [31:0]           sc_wdata_i,
  sc_store_unit_if.master       mem,
  output logic                  sc_done_o,
  output logic                  sc_result_o,
  output logic                  stall_o,
  output logic                  llbit_o
);
  sc_state_e         state, state_n;
  logic              result_q, result_n, kill_q, kill_n, latch, pass, flushing, exc_flush;
  logic [ADDR_W-1:0] link_addr, addr_q;
  logic [31:0]       data_q;

  assign flushing  = flush == FLUSH;
  assign exc_flush = flushing && flush_cause == EXCEPTION;
  // xor-then-shift compares word addresses while still consuming the byte-offset bits
  assign pass = llbit_o && (!CHECK_ADDR || ((link_addr ^ sc_addr_i) >> 2) == '0);

  llsc_link_reg #(.ADDR_W(ADDR_W)) u_link (
    .clk       (clk),
    .rst       (rst),
    .clr_exc   (exc_flush),
    .clr_sc    (state == DONE),
    .set       (ll_valid_i && state == IDLE && !sc_valid_i),
    .set_addr  (ll_addr_i),
    .llbit     (llbit_o),
    .link_addr (link_addr)
  );

  // next state: an accepted store always runs to completion; a flush only kills the done pulse
  always_comb begin
    state_n  = state;
    result_n = result_q;
    kill_n   = kill_q;
    latch    = 1'b0;
    case (state)
      IDLE: if (sc_valid_i && !flushing) begin
        state_n  = pass ? REQ : DONE;
        result_n = SC_FAIL;
        latch    = pass;
      end
      REQ: if (mem.mem_addr_ok_i) begin
        state_n  = mem.mem_data_ok_i ? DONE : WAIT;
        result_n = SC_SUCCESS;
      end
      WAIT: if (mem.mem_data_ok_i) state_n = DONE;
      DONE: begin
        state_n = IDLE;
        kill_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    if (flushing && (state == REQ || state == WAIT)) kill_n = 1'b1;
  end

  // FSM, result, kill flag and the store address/data held stable through the request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      result_q <= SC_FAIL;
      kill_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_n;
      result_q <= result_n;
      kill_q   <= kill_n;
      if (latch) begin
        addr_q <= sc_addr_i;
        data_q <= sc_wdata_i;
      end
    end
  end

  assign mem.mem_req_o   = state == REQ;
  assign mem.mem_wr_o    = mem.mem_req_o ? WRITE_ENABLE : 1'b0;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = data_q;
  assign mem.mem_wsel_o  = 4'b1111;
  assign sc_done_o       = state == DONE && !kill_q && !flushing;
  assign sc_result_o     = sc_done_o && result_q;
  assign stall_o         = sc_valid_i && state != DONE;
endmodule

// File: tb/tb_sc_store_unit.sv
// tb_sc_store_unit: directed table-driven and hand-sequenced checks of the SC store unit
module tb_sc_store_unit;
  import sc_store_unit_pkg::*;

  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, flush_cause = 1'b0;
  logic        ll_valid_i = 1'b0, sc_valid_i = 1'b0;
  logic [31:0] ll_addr_i = '0, sc_addr_i = '0, sc_wdata_i = '0;
  logic        sc_done_o, sc_result_o, stall_o, llbit_o;
  logic        auto_mem = 1'b1, man_aok = 1'b0, man_dok = 1'b0;
  int          n_chk = 0, n_fail = 0;

  sc_store_unit_if #(.ADDR_W(32)) mem ();

  sc_store_unit #(.ADDR_W(32), .CHECK_ADDR(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flush_cause (flush_cause),
    .ll_valid_i  (ll_valid_i),
    .ll_addr_i   (ll_addr_i),
    .sc_valid_i  (sc_valid_i),
    .sc_addr_i   (sc_addr_i),
    .sc_wdata_i  (sc_wdata_i),
    .mem         (mem),
    .sc_done_o   (sc_done_o),
    .sc_result_o (sc_result_o),
    .stall_o     (stall_o),
    .llbit_o     (llbit_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem.mem_addr_ok_i = auto_mem ? mem.mem_req_o : man_aok;
    mem.mem_data_ok_i = auto_mem ? mem.mem_req_o : man_dok;
  end

  typedef struct {
    logic        do_ll;
    logic [31:0] ll_a;
    logic        exc;
    logic [31:0] sc_a;
    logic [31:0] sc_d;
    logic        res;
    int          reqs;
    int          stalls;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ll(input logic [31:0] a);
    ll_valid_i = 1'b1;
    ll_addr_i  = a;
    tick();
    ll_valid_i = 1'b0;
  endtask

  task automatic run_sc(input logic [31:0] a, input logic [31:0] d,
                        output logic res, output int reqs, output int stalls);
    logic ok;
    res = 1'b0; reqs = 0; stalls = 0; ok = 1'b0;
    sc_valid_i = 1'b1; sc_addr_i = a; sc_wdata_i = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (mem.mem_req_o) begin
        reqs++;
        chk("req_addr", mem.mem_addr_o, a);
        chk("req_wdata", mem.mem_wdata_o, d);
        chk("req_wsel", {28'd0, mem.mem_wsel_o}, 32'hF);
        chk("req_wr", {31'd0, mem.mem_wr_o}, 32'd1);
      end
      if (sc_done_o) begin
        ok  = 1'b1;
        res = sc_result_o;
      end
      tick();
    end
    sc_valid_i = 1'b0;
    if (!ok) chk("sc_timeout", 32'd0, 32'd1);
  endtask

  vec_t v[6];

  initial begin
    logic res;
    int   reqs, stalls;
    v[0] = '{1'b1, 32'h1000, 1'b0, 32'h1000, 32'hDEADBEEF, 1'b1, 1, 2};
    v[1] = '{1'b0, 32'h0,    1'b0, 32'h1000, 32'h0BADF00D, 1'b0, 0, 1};
    v[2] = '{1'b1, 32'h2000, 1'b1, 32'h2000, 32'h22222222, 1'b0, 0, 1};
    v[3] = '{1'b1, 32'h3000, 1'b0, 32'h3004, 32'h33333333, 1'b0, 0, 1};
    v[4] = '{1'b1, 32'h3000, 1'b0, 32'h3002, 32'h44444444, 1'b1, 1, 2};
    v[5] = '{1'b1, 32'h4000, 1'b0, 32'h4000, 32'h12345678, 1'b1, 1, 2};

    #12;
    chk("rst_llbit", llbit_o, 0);
    chk("rst_req", mem.mem_req_o, 0);
    chk("rst_done", sc_done_o, 0);
    chk("rst_result", sc_result_o, 0);
    chk("rst_addr", mem.mem_addr_o, 0);
    chk("rst_wdata", mem.mem_wdata_o, 0);
    chk("rst_stall", stall_o, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) begin
      if (v[k].do_ll) begin
        do_ll(v[k].ll_a);
        @(negedge clk);
        chk("vec_llbit_set", llbit_o, 1);
        tick();
      end
      if (v[k].exc) begin
        flush = 1'b1; flush_cause = 1'b1;
        tick();
        flush = 1'b0; flush_cause = 1'b0;
        @(negedge clk);
        chk("vec_llbit_exc_clr", llbit_o, 0);
        tick();
      end
      run_sc(v[k].sc_a, v[k].sc_d, res, reqs, stalls);
      chk("vec_result", res, v[k].res);
      chk("vec_reqs", reqs, v[k].reqs);
      chk("vec_stalls", stalls, v[k].stalls);
      @(negedge clk);
      chk("vec_done_once", sc_done_o, 0);
      chk("vec_llbit_after", llbit_o, 0);
      tick();
    end

    do_ll(32'h5000);
    auto_mem = 1'b0;
    sc_valid_i = 1'b1; sc_addr_i = 32'h5000; sc_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("dly_idle_req", mem.mem_req_o, 0);
    chk("dly_idle_stall", stall_o, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      man_aok = (i == 3);
      @(negedge clk);
      chk("dly_req_hold", mem.mem_req_o, 1);
      chk("dly_addr_hold", mem.mem_addr_o, 32'h5000);
      chk("dly_data_hold", mem.mem_wdata_o, 32'hCAFEF00D);
      chk("dly_req_stall", stall_o, 1);
      tick();
      man_aok = 1'b0;
    end
    @(negedge clk);
    chk("dly_wait_req", mem.mem_req_o, 0);
    chk("dly_wait_stall", stall_o, 1);
    chk("dly_wait_done", sc_done_o, 0);
    tick();
    man_dok = 1'b1;
    @(negedge clk);
    chk("dly_dok_done", sc_done_o, 0);
    chk("dly_dok_stall", stall_o, 1);
    tick();
    man_dok = 1'b0;
    @(negedge clk);
    chk("dly_done", sc_done_o, 1);
    chk("dly_result", sc_result_o, 1);
    chk("dly_done_stall", stall_o, 0);
    tick();
    sc_valid_i = 1'b0;
    @(negedge clk);
    chk("dly_llbit_after", llbit_o, 0);
    chk("dly_done_once", sc_done_o, 0);
    tick();

    do_ll(32'h6000);
    sc_valid_i = 1'b1; sc_addr_i = 32'h6000; sc_wdata_i = 32'h66666666;
    tick();
    man_aok = 1'b1;
    @(negedge clk);
    chk("int_req", mem.mem_req_o, 1);
    tick();
    man_aok = 1'b0;
    flush = 1'b1; flush_cause = 1'b0; sc_valid_i = 1'b0;
    @(negedge clk);
    chk("int_wait_req", mem.mem_req_o, 0);
    chk("int_flush_done", sc_done_o, 0);
    tick();
    flush = 1'b0;
    man_dok = 1'b1;
    @(negedge clk);
    chk("int_dok_done", sc_done_o, 0);
    tick();
    man_dok = 1'b0;
    @(negedge clk);
    chk("int_state_done", dut.state, DONE);
    chk("int_killed_done", sc_done_o, 0);
    tick();
    @(negedge clk);
    chk("int_state_idle", dut.state, IDLE);
    chk("int_llbit", llbit_o, 0);
    chk("int_no_done", sc_done_o, 0);
    tick();

    sc_valid_i = 1'b1; sc_addr_i = 32'h6100; sc_wdata_i = 32'h0;
    tick();
    flush = 1'b1; flush_cause = 1'b0; sc_valid_i = 1'b0;
    @(negedge clk);
    chk("dflush_state", dut.state, DONE);
    chk("dflush_done", sc_done_o, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("dflush_idle", dut.state, IDLE);
    tick();

    do_ll(32'h7000);
    sc_valid_i = 1'b1; sc_addr_i = 32'h7000; sc_wdata_i = 32'h77777777;
    tick();
    @(negedge clk);
    chk("rstmid_req", mem.mem_req_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_req_low", mem.mem_req_o, 0);
    chk("rstmid_addr", mem.mem_addr_o, 0);
    chk("rstmid_wdata", mem.mem_wdata_o, 0);
    chk("rstmid_llbit", llbit_o, 0);
    chk("rstmid_done", sc_done_o, 0);
    sc_valid_i = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rstmid_idle", dut.state, IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
